branch_flush_controller: RTL and testbench

//  Pipeline hazard controller that sequences the execute-stage conditional unit's branch outcome.
//  - On BranchTakenE it redirects fetch and squashes the wrong-path instructions in D and E.
//  - Interlocks a decode-stage branch behind an E-stage flag write.
//  - Freezes F/D/E while the memory stage is busy.
//  - Sits between the conditional unit, the PC mux and the F/D and D/E pipeline registers.

---
 rtl/branch_flush_controller.sv | 195 +++++++++++++++++++
 tb/tb_branch_flush_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_flush_controller.sv
// rtl/branch_flush_controller.sv - branch redirect / flush / stall sequencer for the F-D-E pipeline
//
// Purpose:
//   Turns the execute-stage branch outcome into a PC redirect and a multi-cycle
//   squash of the F/D and D/E registers. It also interlocks a decode-stage branch
//   behind an execute-stage flag write, and freezes F/D/E while memory is busy.
//   All outputs are Mealy, so a taken branch flushes in its own cycle.
//
// Optional feature:
//   BRANCH_STATS_EN - adds the saturating BranchCountO and FlushCycleCountO counters.
//
// Ports:
//   clk              pipeline clock, rising edge
//   rst              synchronous reset, active-low
//   BranchD          branch instruction present in decode
//   BranchTakenE     branch taken, from the conditional unit
//   FlagWriteE[1:0]  flag-write enables of the instruction in execute
//   MemBusyM         memory stage busy; the whole front pipeline holds
//   StallF/D/E       hold the PC, F/D and D/E registers
//   FlushD/E         clear the F/D and D/E registers
//   PCSelF           1 = next PC is the branch target
//   StateO[1:0]      current FSM state (debug)
//   BranchCountO     (BRANCH_STATS_EN) cycles with PCSelF=1
//   FlushCycleCountO (BRANCH_STATS_EN) branch-caused FlushE cycles

module branch_flush_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             BranchD,
    input  logic             BranchTakenE,
    input  logic [1:0]       FlagWriteE,
    input  logic             MemBusyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             PCSelF,
    output logic [1:0]       StateO
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] BranchCountO,
    output logic [CNT_W-1:0] FlushCycleCountO
`endif
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_RUN     = 2'b00;
    localparam logic [1:0] S_FLUSH   = 2'b01;
    localparam logic [1:0] S_MEMWAIT = 2'b10;

    if (FLUSH_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
        $error("branch_flush_controller: FLUSH_CYCLES and CNT_W must be >= 1");
    end

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          interlock;

    assign interlock = BranchD && (FlagWriteE != 2'b00);
    assign StateO    = state;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_RUN: begin
                if (MemBusyM) begin
                    // Branch stays latched in the held D/E register and is taken later
                    state_nxt = S_MEMWAIT;
                end else if (BranchTakenE && (FLUSH_CYCLES > 1)) begin
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!MemBusyM) begin
                    // cnt is the number of flush cycles still owed, this one included
                    if (cnt <= CNT_ONE) begin
                        state_nxt = S_RUN;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
            end
            S_MEMWAIT: begin
                if (!MemBusyM) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    // Output logic
`ifdef BRANCH_STATS_EN
    logic branch_flush;
`endif

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        PCSelF = 1'b0;
`ifdef BRANCH_STATS_EN
        branch_flush = 1'b0;
`endif
        if (!rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            case (state)
                S_RUN: begin
                    if (MemBusyM) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                    end else if (BranchTakenE) begin
                        PCSelF = 1'b1;
                        FlushD = 1'b1;
                        FlushE = 1'b1;
`ifdef BRANCH_STATS_EN
                        branch_flush = 1'b1;
`endif
                    end else if (interlock) begin
                        // Hold the branch in D and send a bubble into E
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (MemBusyM) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                    end else begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
`ifdef BRANCH_STATS_EN
                        branch_flush = 1'b1;
`endif
                    end
                end
                S_MEMWAIT: begin
                    if (MemBusyM) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            BranchCountO     <= '0;
            FlushCycleCountO <= '0;
        end else begin
            if (PCSelF && (BranchCountO != '1)) begin
                BranchCountO <= BranchCountO + CNT_W'(1);
            end
            if (branch_flush && (FlushCycleCountO != '1)) begin
                FlushCycleCountO <= FlushCycleCountO + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_flush_controller.sv
// tb/tb_branch_flush_controller.sv - scoreboard bench for branch_flush_controller

module tb_branch_flush_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: FLUSH_CYCLES=2, CNT_W=2
    logic       a_rst = 1'b0, a_bd = 1'b0, a_bt = 1'b0, a_mb = 1'b0;
    logic [1:0] a_fw = 2'b00;
    logic       a_sf, a_sd, a_se, a_fd, a_fe, a_pc;
    logic [1:0] a_st;
`ifdef BRANCH_STATS_EN
    logic [1:0] a_brc, a_flc;
`endif

    // Instance B: FLUSH_CYCLES=3
    logic       b_rst = 1'b0, b_bd = 1'b0, b_bt = 1'b0, b_mb = 1'b0;
    logic [1:0] b_fw = 2'b00;
    logic       b_sf, b_sd, b_se, b_fd, b_fe, b_pc;
    logic [1:0] b_st;
`ifdef BRANCH_STATS_EN
    logic [15:0] b_brc, b_flc;
`endif

    branch_flush_controller #(.FLUSH_CYCLES(2), .CNT_W(2)) dut (
        .clk(clk), .rst(a_rst), .BranchD(a_bd), .BranchTakenE(a_bt),
        .FlagWriteE(a_fw), .MemBusyM(a_mb),
        .StallF(a_sf), .StallD(a_sd), .StallE(a_se),
        .FlushD(a_fd), .FlushE(a_fe), .PCSelF(a_pc), .StateO(a_st)
`ifdef BRANCH_STATS_EN
        , .BranchCountO(a_brc), .FlushCycleCountO(a_flc)
`endif
    );

    branch_flush_controller #(.FLUSH_CYCLES(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst(b_rst), .BranchD(b_bd), .BranchTakenE(b_bt),
        .FlagWriteE(b_fw), .MemBusyM(b_mb),
        .StallF(b_sf), .StallD(b_sd), .StallE(b_se),
        .FlushD(b_fd), .FlushE(b_fe), .PCSelF(b_pc), .StateO(b_st)
`ifdef BRANCH_STATS_EN
        , .BranchCountO(b_brc), .FlushCycleCountO(b_flc)
`endif
    );

    // Output vector: {StallF, StallD, StallE, FlushD, FlushE, PCSelF, StateO}
    wire [7:0] a_vec = {a_sf, a_sd, a_se, a_fd, a_fe, a_pc, a_st};
    wire [7:0] b_vec = {b_sf, b_sd, b_se, b_fd, b_fe, b_pc, b_st};

    logic [7:0] exp_q[$];
    logic [3:0] cnt_q[$];
    int nvec  = 0;
    int nfail = 0;

    // Stimulus word: {rst, BranchD, BranchTakenE, FlagWriteE[1:0], MemBusyM}
    task automatic drive_a(input logic [5:0] s);
        @(posedge clk);
        #1;
        {a_rst, a_bd, a_bt, a_fw, a_mb} = s;
    endtask

    task automatic drive_b(input logic [5:0] s);
        @(posedge clk);
        #1;
        {b_rst, b_bd, b_bt, b_fw, b_mb} = s;
    endtask

    task automatic test_reset;
        logic [13:0] tbl [3];
        logic [7:0]  e;
        tbl = '{{6'b0_0_0_00_0, 8'b000_11_0_00},
                {6'b0_0_0_00_0, 8'b000_11_0_00},
                {6'b1_0_0_00_0, 8'b000_00_0_00}};
        for (int i = 0; i < 3; i++) begin
            drive_a(tbl[i][13:8]);
            exp_q.push_back(tbl[i][7:0]);
            @(negedge clk);
            e = exp_q.pop_front();
            nvec++;
            if (a_vec !== e) begin
                nfail++;
                $display("FAIL reset step %0d: got %b expected %b", i, a_vec, e);
            end
        end
    endtask

    task automatic test_branch;
        logic [13:0] tbl [3];
        logic [7:0]  e;
        tbl = '{{6'b1_0_1_00_0, 8'b000_11_1_00},
                {6'b1_0_0_00_0, 8'b000_11_0_01},
                {6'b1_0_0_00_0, 8'b000_00_0_00}};
        for (int i = 0; i < 3; i++) begin
            drive_a(tbl[i][13:8]);
            exp_q.push_back(tbl[i][7:0]);
            @(negedge clk);
            e = exp_q.pop_front();
            nvec++;
            if (a_vec !== e) begin
                nfail++;
                $display("FAIL branch step %0d: got %b expected %b", i, a_vec, e);
            end
        end
    endtask

    task automatic test_interlock;
        logic [13:0] tbl [6];
        logic [7:0]  e;
        tbl = '{{6'b1_1_0_01_0, 8'b110_01_0_00},
                {6'b1_0_0_00_0, 8'b000_00_0_00},
                {6'b1_1_0_10_0, 8'b110_01_0_00},
                {6'b1_1_0_11_0, 8'b110_01_0_00},
                {6'b1_1_0_00_0, 8'b000_00_0_00},
                {6'b1_0_0_11_0, 8'b000_00_0_00}};
        for (int i = 0; i < 6; i++) begin
            drive_a(tbl[i][13:8]);
            exp_q.push_back(tbl[i][7:0]);
            @(negedge clk);
            e = exp_q.pop_front();
            nvec++;
            if (a_vec !== e) begin
                nfail++;
                $display("FAIL interlock step %0d: got %b expected %b", i, a_vec, e);
            end
        end
    endtask

    task automatic test_mem_hold;
        logic [13:0] tbl [7];
        logic [7:0]  e;
        tbl = '{{6'b1_0_1_00_1, 8'b111_00_0_00},
                {6'b1_0_1_00_1, 8'b111_00_0_10},
                {6'b1_0_1_00_1, 8'b111_00_0_10},
                {6'b1_0_1_00_0, 8'b000_00_0_10},
                {6'b1_0_1_00_0, 8'b000_11_1_00},
                {6'b1_0_0_00_0, 8'b000_11_0_01},
                {6'b1_0_0_00_0, 8'b000_00_0_00}};
        for (int i = 0; i < 7; i++) begin
            drive_a(tbl[i][13:8]);
            exp_q.push_back(tbl[i][7:0]);
            @(negedge clk);
            e = exp_q.pop_front();
            nvec++;
            if (a_vec !== e) begin
                nfail++;
                $display("FAIL mem_hold step %0d: got %b expected %b", i, a_vec, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [13:0] tbl [5];
        logic [7:0]  e;
        tbl = '{{6'b1_0_1_00_0, 8'b000_11_1_00},
                {6'b1_1_1_11_0, 8'b000_11_0_01},
                {6'b1_0_1_00_0, 8'b000_11_1_00},
                {6'b1_0_0_00_0, 8'b000_11_0_01},
                {6'b1_0_0_00_0, 8'b000_00_0_00}};
        for (int i = 0; i < 5; i++) begin
            drive_a(tbl[i][13:8]);
            exp_q.push_back(tbl[i][7:0]);
            @(negedge clk);
            e = exp_q.pop_front();
            nvec++;
            if (a_vec !== e) begin
                nfail++;
                $display("FAIL back_to_back step %0d: got %b expected %b", i, a_vec, e);
            end
        end
    endtask

    task automatic test_reset_abort;
        logic [13:0] tbl [6];
        logic [7:0]  e;
        tbl = '{{6'b1_0_1_00_0, 8'b000_11_1_00},
                {6'b0_0_0_00_0, 8'b000_11_0_01},
                {6'b1_0_0_00_0, 8'b000_00_0_00},
                {6'b1_0_0_00_1, 8'b111_00_0_00},
                {6'b0_0_0_00_1, 8'b000_11_0_10},
                {6'b1_0_0_00_0, 8'b000_00_0_00}};
        for (int i = 0; i < 6; i++) begin
            drive_a(tbl[i][13:8]);
            exp_q.push_back(tbl[i][7:0]);
            @(negedge clk);
            e = exp_q.pop_front();
            nvec++;
            if (a_vec !== e) begin
                nfail++;
                $display("FAIL reset_abort step %0d: got %b expected %b", i, a_vec, e);
            end
        end
    endtask

    task automatic test_busy_flush;
        logic [13:0] tbl [8];
        logic [7:0]  e;
        tbl = '{{6'b0_0_0_00_0, 8'b000_11_0_00},
                {6'b1_0_0_00_0, 8'b000_00_0_00},
                {6'b1_0_1_00_0, 8'b000_11_1_00},
                {6'b1_0_0_00_1, 8'b111_00_0_01},
                {6'b1_0_0_00_1, 8'b111_00_0_01},
                {6'b1_0_0_00_0, 8'b000_11_0_01},
                {6'b1_0_0_00_0, 8'b000_11_0_01},
                {6'b1_0_0_00_0, 8'b000_00_0_00}};
        for (int i = 0; i < 8; i++) begin
            drive_b(tbl[i][13:8]);
            exp_q.push_back(tbl[i][7:0]);
            @(negedge clk);
            e = exp_q.pop_front();
            nvec++;
            if (b_vec !== e) begin
                nfail++;
                $display("FAIL busy_flush step %0d: got %b expected %b", i, b_vec, e);
            end
        end
    endtask

`ifdef BRANCH_STATS_EN
    // Counters are registered: expected values reflect the cycles before each sample
    task automatic test_stats;
        logic [17:0] tbl [14];
        logic [7:0]  e;
        logic [3:0]  c;
        tbl = '{{6'b0_0_0_00_0, 8'b000_11_0_00, 4'b00_00},
                {6'b1_1_0_01_0, 8'b110_01_0_00, 4'b00_00},
                {6'b1_0_1_00_0, 8'b000_11_1_00, 4'b00_00},
                {6'b1_0_0_00_0, 8'b000_11_0_01, 4'b01_01},
                {6'b1_0_1_00_0, 8'b000_11_1_00, 4'b01_10},
                {6'b1_0_0_00_0, 8'b000_11_0_01, 4'b10_11},
                {6'b1_0_1_00_0, 8'b000_11_1_00, 4'b10_11},
                {6'b1_0_0_00_0, 8'b000_11_0_01, 4'b11_11},
                {6'b1_0_1_00_0, 8'b000_11_1_00, 4'b11_11},
                {6'b1_0_0_00_0, 8'b000_11_0_01, 4'b11_11},
                {6'b1_0_1_00_0, 8'b000_11_1_00, 4'b11_11},
                {6'b0_0_0_00_0, 8'b000_11_0_01, 4'b11_11},
                {6'b1_0_0_00_0, 8'b000_00_0_00, 4'b00_00},
                {6'b1_0_0_00_0, 8'b000_00_0_00, 4'b00_00}};
        for (int i = 0; i < 14; i++) begin
            drive_a(tbl[i][17:12]);
            exp_q.push_back(tbl[i][11:4]);
            cnt_q.push_back(tbl[i][3:0]);
            @(negedge clk);
            e = exp_q.pop_front();
            c = cnt_q.pop_front();
            nvec++;
            if (a_vec !== e) begin
                nfail++;
                $display("FAIL stats_outputs step %0d: got %b expected %b", i, a_vec, e);
            end
            nvec++;
            if ({a_brc, a_flc} !== c) begin
                nfail++;
                $display("FAIL stats_counters step %0d: got br=%0d fl=%0d expected br=%0d fl=%0d",
                         i, a_brc, a_flc, c[3:2], c[1:0]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_branch();
        test_interlock();
        test_mem_hold();
        test_back_to_back();
        test_reset_abort();
        test_busy_flush();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
